// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM states.
// Imported by the ALU top, its multiplier and the decoder/bench side.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_EQ   = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_SLTU;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial-product step per cycle, N steps.
// The first step is folded into the start cycle so the product is ready N cycles after start.
module alu_mul_seq #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] prod
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    logic           busy;
    logic [CW-1:0]  step;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            step   <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                step   <= step + 1'b1;
                if (step == LAST_STEP) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                // step 0 happens here: bit 0 of b selects the unshifted multiplicand
                acc    <= b[0] ? {{N{1'b0}}, a} : '0;
                mcand  <= {{N{1'b0}}, a} << 1;
                mplier <= b >> 1;
                step   <= CW'(1);
                busy   <= 1'b1;
            end
        end
    end

    assign prod = acc;

endmodule

// File: rtl/alu_seq.sv
// Clocked, handshaked ALU: single-cycle ops complete the cycle after accept,
// MUL runs on the shift-add multiplier. One operation in flight at a time.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         overflow,
    output logic         zero,
    output logic         illegal
);

    localparam int unsigned SHW = $clog2(N);

    state_e state;

    logic           accept;
    logic           mul_start;
    logic           mul_done;
    logic [2*N-1:0] mul_prod;

    logic [N:0]        sum_ext;
    logic [N:0]        diff_ext;
    logic              add_ovf;
    logic              sub_ovf;
    logic [SHW-1:0]    shamt;
    logic [N:0]        sll_ext;
    logic [N:0]        srl_ext;
    logic signed [N:0] sra_in;
    logic [N:0]        sra_ext;

    logic [N-1:0] dp_result;
    logic         dp_carry;
    logic         dp_ovf;
    logic         dp_illegal;

    assign in_ready  = (state == S_IDLE) && !out_valid;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_seq #(
        .N(N)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        add_ovf  = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
        sub_ovf  = (a[N-1] != b[N-1]) && (diff_ext[N-1] != a[N-1]);

        // Shifts run on an N+1 bit field so the extra bit catches the last bit shifted out
        shamt   = b[SHW-1:0];
        sll_ext = {1'b0, a} << shamt;
        srl_ext = {a, 1'b0} >> shamt;
        sra_in  = {a, 1'b0};
        sra_ext = sra_in >>> shamt;

        dp_result  = '0;
        dp_carry   = 1'b0;
        dp_ovf     = 1'b0;
        dp_illegal = !op_is_legal(op);

        case (op)
            OP_ADD: begin
                dp_result = sum_ext[N-1:0];
                dp_carry  = sum_ext[N];
                dp_ovf    = add_ovf;
            end
            OP_SUB: begin
                dp_result = diff_ext[N-1:0];
                dp_carry  = diff_ext[N];
                dp_ovf    = sub_ovf;
            end
            OP_NOT: dp_result = ~a;
            OP_AND: dp_result = a & b;
            OP_OR:  dp_result = a | b;
            OP_XOR: dp_result = a ^ b;
            OP_SLT: begin
                dp_result = {{(N-1){1'b0}}, diff_ext[N-1] ^ sub_ovf};
                dp_carry  = diff_ext[N];
                dp_ovf    = sub_ovf;
            end
            OP_EQ: begin
                dp_result = {{(N-1){1'b0}}, a == b};
                dp_carry  = diff_ext[N];
                dp_ovf    = sub_ovf;
            end
            OP_SLL: begin
                dp_result = sll_ext[N-1:0];
                dp_carry  = sll_ext[N];
            end
            OP_SRL: begin
                dp_result = srl_ext[N:1];
                dp_carry  = srl_ext[0];
            end
            OP_SRA: begin
                dp_result = sra_ext[N:1];
                dp_carry  = sra_ext[0];
            end
            OP_SLTU: begin
                dp_result = {{(N-1){1'b0}}, a < b};
                dp_carry  = diff_ext[N];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state <= S_MUL;
                        end else begin
                            result    <= dp_result;
                            carry     <= dp_carry;
                            overflow  <= dp_ovf;
                            zero      <= (dp_result == '0);
                            illegal   <= dp_illegal;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        result    <= mul_prod[N-1:0];
                        carry     <= |mul_prod[2*N-1:N];
                        overflow  <= 1'b0;
                        zero      <= (mul_prod[N-1:0] == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=4): directed vector table plus hand-written
// sequences for reset during MUL and output backpressure.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         illegal;

    int n_cmp = 0;
    int n_fail = 0;

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                                input logic [N-1:0] r, input logic c, input logic v,
                                input logic z, input logic il, input int lat);
        vec_t t;
        t.op = o; t.a = x; t.b = y; t.res = r;
        t.c = c; t.v = v; t.z = z; t.ill = il; t.lat = lat;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents one op, returns the number of rising edges from accept until out_valid is seen.
    task automatic run_op(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                          output int lat);
        @(negedge clk);
        check("in_ready_before_op", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            check("in_ready_while_busy", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_consume", out_valid, 0);
        check("in_ready_after_consume", in_ready, 1);
    endtask

    task automatic check_vec(input vec_t t, input int lat, input string tag);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_result"}, result, t.res);
        check({tag, "_carry"}, carry, t.c);
        check({tag, "_overflow"}, overflow, t.v);
        check({tag, "_zero"}, zero, t.z);
        check({tag, "_illegal"}, illegal, t.ill);
        check({tag, "_latency"}, lat, t.lat);
    endtask

    initial begin
        int lat;
        logic [N-1:0] held_res;
        logic [4:0]   held_flags;

        vecs.push_back(mk(OP_ADD,  4'b0111, 4'b0001, 4'b1000, 0, 1, 0, 0, 1));
        vecs.push_back(mk(OP_SUB,  4'b0011, 4'b0011, 4'b0000, 1, 0, 1, 0, 1));
        vecs.push_back(mk(OP_SLT,  4'b1000, 4'b0001, 4'b0001, 1, 1, 0, 0, 1));
        vecs.push_back(mk(OP_SLTU, 4'b1000, 4'b0001, 4'b0000, 1, 0, 1, 0, 1));
        vecs.push_back(mk(OP_EQ,   4'b0101, 4'b0101, 4'b0001, 1, 0, 0, 0, 1));
        vecs.push_back(mk(OP_SRA,  4'b1000, 4'b0010, 4'b1110, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_MUL,  4'b0111, 4'b0011, 4'b0101, 1, 0, 0, 0, 5));
        vecs.push_back(mk(OP_ADD,  4'b1111, 4'b0001, 4'b0000, 1, 0, 1, 0, 1));
        vecs.push_back(mk(OP_SUB,  4'b0010, 4'b0011, 4'b1111, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_SUB,  4'b1000, 4'b0001, 4'b0111, 1, 1, 0, 0, 1));
        vecs.push_back(mk(OP_NOT,  4'b1010, 4'b0000, 4'b0101, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_AND,  4'b1100, 4'b1010, 4'b1000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_OR,   4'b1100, 4'b1010, 4'b1110, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_XOR,  4'b1100, 4'b1010, 4'b0110, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_SLL,  4'b0110, 4'b0011, 4'b0000, 1, 0, 1, 0, 1));
        vecs.push_back(mk(OP_SRL,  4'b0110, 4'b0000, 4'b0110, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_SRL,  4'b0101, 4'b0001, 4'b0010, 1, 0, 0, 0, 1));
        vecs.push_back(mk(OP_SRA,  4'b0100, 4'b0111, 4'b0000, 1, 0, 1, 0, 1));
        vecs.push_back(mk(OP_EQ,   4'b0101, 4'b0100, 4'b0000, 1, 0, 1, 0, 1));
        vecs.push_back(mk(OP_SLTU, 4'b0001, 4'b1000, 4'b0001, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_MUL,  4'b1111, 4'b1111, 4'b0001, 1, 0, 0, 0, 5));
        vecs.push_back(mk(OP_MUL,  4'b0000, 4'b1011, 4'b0000, 0, 0, 1, 0, 5));
        vecs.push_back(mk(4'd14,   4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 1, 1));
        vecs.push_back(mk(OP_ADD,  4'b0001, 4'b0010, 4'b0011, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'd13,   4'b0101, 4'b0011, 4'b0000, 0, 0, 1, 1, 1));
        vecs.push_back(mk(4'd15,   4'b1010, 4'b0110, 4'b0000, 0, 0, 1, 1, 1));
        vecs.push_back(mk(OP_SLL,  4'b1001, 4'b0001, 4'b0010, 1, 0, 0, 0, 1));

        // Reset state
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", {carry, overflow, zero, illegal}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check_vec(vecs[i], lat, $sformatf("vec%0d", i));
            consume();
        end

        // Reset in the middle of a MUL: previous result is nonzero so clearing is observable
        run_op(OP_ADD, 4'b0011, 4'b0100, lat);
        consume();
        @(negedge clk);
        op = OP_MUL; a = 4'b0111; b = 4'b0011; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midmul_rst_out_valid", out_valid, 0);
        check("midmul_rst_in_ready", in_ready, 1);
        check("midmul_rst_result", result, 0);
        check("midmul_rst_flags", {carry, overflow, zero, illegal}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_ADD, 4'b0001, 4'b0001, lat);
        check_vec(mk(OP_ADD, 4'b0001, 4'b0001, 4'b0010, 0, 0, 0, 0, 1), lat, "post_rst_add");
        consume();
        run_op(OP_MUL, 4'b0010, 4'b0011, lat);
        check_vec(mk(OP_MUL, 4'b0010, 4'b0011, 4'b0110, 0, 0, 0, 0, 5), lat, "post_rst_mul");
        consume();

        // Backpressure: result held for 3 cycles while a competing op is offered
        run_op(OP_ADD, 4'b0111, 4'b0001, lat);
        check_vec(mk(OP_ADD, 4'b0111, 4'b0001, 4'b1000, 0, 1, 0, 0, 1), lat, "bp_first");
        held_res   = result;
        held_flags = {out_valid, carry, overflow, zero, illegal};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            op = OP_SUB; a = 4'b0000; b = 4'b0001; in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_result_stable", result, 4'b1000);
            check("bp_flags_stable", {out_valid, carry, overflow, zero, illegal}, 5'b1_0100);
            check("bp_in_ready_low", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_held_result_same", result, held_res);
        check("bp_held_flags_same", {out_valid, carry, overflow, zero, illegal}, held_flags);
        consume();
        @(posedge clk); #1;
        check("bp_no_stray_accept", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
